// File: rtl/sa_axis_pkg.sv
// rtl/sa_axis_pkg.sv - shared types and helpers for the systolic-array AXIS host driver
// Purpose: default element widths, the host-driver state encoding and a
//          constant-evaluable ceil(log2) used to size counters and addresses.
package sa_axis_pkg;

  localparam int DW_DEF = 8;
  localparam int OW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    GAP,
    SEND_B,
    RECV_C
  } state_e;

  // ceil(log2(v)), never less than 1 so that every derived vector is legal
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one synchronous read port
// Purpose: element storage for the A, B and C matrices.
// Ports:   clk, rst_n (clears only the read register), we_i/waddr_i/wdata_i write port,
//          raddr_i/rdata_o read port with one cycle of latency.
module sdp_ram
  import sa_axis_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_o <= '0;
    else        rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/axis_sa_host_driver.sv
// rtl/axis_sa_host_driver.sv - host-side AXIS driver for the output-stationary systolic array
// Purpose: holds A (MxN) and B (NxL), streams A then (after GAP_CYC idle cycles) B
//          row-major as an AXIS master, and captures C (MxL) from an AXIS slave port
//          into a result RAM the host reads back.
// Ports:   clk/rst_n; cfg_we/cfg_sel/cfg_addr/cfg_wdata load port; start/busy/done/err
//          run control; res_raddr/res_rdata result read port; m_axis_a_*, m_axis_b_*
//          master streams; s_axis_c_* slave stream.
module axis_sa_host_driver
  import sa_axis_pkg::*;
#(
  parameter int  M       = 25,
  parameter int  N       = 19,
  parameter int  L       = 17,
  parameter int  DW      = DW_DEF,
  parameter int  OW      = OW_DEF,
  parameter int  GAP_CYC = 10,
  localparam int AW      = clog2((M * N > N * L) ? M * N : N * L),
  localparam int CW      = clog2(M * L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [CW-1:0] res_raddr,
  output logic [OW-1:0] res_rdata,
  output logic [DW-1:0] m_axis_a_tdata,
  output logic          m_axis_a_tvalid,
  input  logic          m_axis_a_tready,
  output logic          m_axis_a_tlast,
  output logic [DW-1:0] m_axis_b_tdata,
  output logic          m_axis_b_tvalid,
  input  logic          m_axis_b_tready,
  output logic          m_axis_b_tlast,
  input  logic [OW-1:0] s_axis_c_tdata,
  input  logic          s_axis_c_tvalid,
  output logic          s_axis_c_tready,
  input  logic          s_axis_c_tlast
);

  localparam int NA = M * N;
  localparam int NB = N * L;
  localparam int NC = M * L;
  localparam int FW = clog2(((NA > NB) ? NA : NB) + 1);
  localparam int GW = clog2(GAP_CYC + 1);

  state_e        state_q;
  logic          busy_q, done_q, err_q;
  logic [FW-1:0] a_cnt_q, b_cnt_q;   // next element index to fetch from RAM
  logic [CW-1:0] c_cnt_q;            // next result RAM slot
  logic [GW-1:0] gap_q;
  logic          stg_vld_q;          // RAM read register holds element stg_idx_q
  logic [AW-1:0] stg_idx_q;
  logic [DW-1:0] a_tdata_q, b_tdata_q;
  logic          a_tvalid_q, a_tlast_q, b_tvalid_q, b_tlast_q;
  logic          c_tready_q;

  logic          snd_a, snd_b, sending;
  logic [FW-1:0] cur_cnt, cur_total;
  logic          out_vld, out_last, out_rdy, out_hs, load_out, issue, stg_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_a_rdata, ram_b_rdata, ram_rdata;
  logic          we_a, we_b, c_acc, c_last;

  // A and B are never streamed at the same time, so one prefetch stage serves both.
  assign snd_a     = (state_q == SEND_A);
  assign snd_b     = (state_q == SEND_B);
  assign sending   = snd_a | snd_b;
  assign cur_cnt   = snd_a ? a_cnt_q : b_cnt_q;
  assign cur_total = snd_a ? FW'(NA) : FW'(NB);
  assign out_vld   = snd_a ? a_tvalid_q : b_tvalid_q;
  assign out_last  = snd_a ? a_tlast_q : b_tlast_q;
  assign out_rdy   = snd_a ? m_axis_a_tready : m_axis_b_tready;
  assign out_hs    = sending & out_vld & out_rdy;
  assign load_out  = sending & stg_vld_q & (~out_vld | out_rdy);
  assign issue     = sending & (cur_cnt < cur_total) & (~stg_vld_q | load_out);
  // While the staged element waits, its address is re-presented so the read register holds it.
  assign rd_addr   = issue ? cur_cnt[AW-1:0] : stg_idx_q;
  assign ram_rdata = snd_a ? ram_a_rdata : ram_b_rdata;
  assign stg_last  = (FW'(stg_idx_q) == cur_total - FW'(1));

  assign we_a   = cfg_we & ~busy_q & ~cfg_sel & (int'(cfg_addr) < NA);
  assign we_b   = cfg_we & ~busy_q &  cfg_sel & (int'(cfg_addr) < NB);
  assign c_acc  = s_axis_c_tvalid & c_tready_q;
  assign c_last = (c_cnt_q == CW'(NC - 1));

  sdp_ram #(.WIDTH(DW), .DEPTH(NA), .AW(AW)) u_ram_a (
    .clk(clk), .rst_n(rst_n), .we_i(we_a), .waddr_i(cfg_addr), .wdata_i(cfg_wdata),
    .raddr_i(rd_addr), .rdata_o(ram_a_rdata)
  );

  sdp_ram #(.WIDTH(DW), .DEPTH(NB), .AW(AW)) u_ram_b (
    .clk(clk), .rst_n(rst_n), .we_i(we_b), .waddr_i(cfg_addr), .wdata_i(cfg_wdata),
    .raddr_i(rd_addr), .rdata_o(ram_b_rdata)
  );

  sdp_ram #(.WIDTH(OW), .DEPTH(NC), .AW(CW)) u_ram_c (
    .clk(clk), .rst_n(rst_n), .we_i(c_acc), .waddr_i(c_cnt_q), .wdata_i(s_axis_c_tdata),
    .raddr_i(res_raddr), .rdata_o(res_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      c_cnt_q    <= '0;
      gap_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_idx_q  <= '0;
      a_tdata_q  <= '0;
      a_tvalid_q <= 1'b0;
      a_tlast_q  <= 1'b0;
      b_tdata_q  <= '0;
      b_tvalid_q <= 1'b0;
      b_tlast_q  <= 1'b0;
      c_tready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // busy lingers one cycle past done so the host sees done while still busy
      if (done_q) busy_q <= 1'b0;

      if (sending) begin
        stg_vld_q <= issue | (stg_vld_q & ~load_out);
        if (issue) begin
          stg_idx_q <= cur_cnt[AW-1:0];
          if (snd_a) a_cnt_q <= a_cnt_q + FW'(1);
          else       b_cnt_q <= b_cnt_q + FW'(1);
        end
        if (snd_a) begin
          if (load_out)    {a_tvalid_q, a_tlast_q, a_tdata_q} <= {1'b1, stg_last, ram_rdata};
          else if (out_hs) {a_tvalid_q, a_tlast_q} <= 2'b00;
        end else begin
          if (load_out)    {b_tvalid_q, b_tlast_q, b_tdata_q} <= {1'b1, stg_last, ram_rdata};
          else if (out_hs) {b_tvalid_q, b_tlast_q} <= 2'b00;
        end
      end

      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            state_q   <= SEND_A;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            c_cnt_q   <= '0;
            gap_q     <= '0;
            stg_vld_q <= 1'b0;
          end
        end
        SEND_A: begin
          if (out_hs && out_last) begin
            stg_vld_q <= 1'b0;
            if (GAP_CYC == 0) begin
              state_q    <= SEND_B;
              c_tready_q <= 1'b1;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (int'(gap_q) >= GAP_CYC - 1) begin
            state_q    <= SEND_B;
            c_tready_q <= 1'b1;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        SEND_B: begin
          if (out_hs && out_last) begin
            stg_vld_q <= 1'b0;
            state_q   <= RECV_C;
          end
        end
        default: ;
      endcase

      // C capture overrides the state update: the M*L-th beat ends the run regardless of tlast.
      if (c_acc) begin
        if (!c_last) c_cnt_q <= c_cnt_q + CW'(1);
        if (s_axis_c_tlast != c_last) err_q <= 1'b1;
        if (c_last) begin
          done_q     <= 1'b1;
          c_tready_q <= 1'b0;
          state_q    <= IDLE;
          stg_vld_q  <= 1'b0;
          b_tvalid_q <= 1'b0;
          b_tlast_q  <= 1'b0;
        end
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign m_axis_a_tdata  = a_tdata_q;
  assign m_axis_a_tvalid = a_tvalid_q;
  assign m_axis_a_tlast  = a_tlast_q;
  assign m_axis_b_tdata  = b_tdata_q;
  assign m_axis_b_tvalid = b_tvalid_q;
  assign m_axis_b_tlast  = b_tlast_q;
  assign s_axis_c_tready = c_tready_q;

endmodule

// File: tb/tb_axis_sa_host_driver.sv
// tb/tb_axis_sa_host_driver.sv - self-checking bench for axis_sa_host_driver
module tb_axis_sa_host_driver;

  localparam int M = 25, N = 19, L = 17, GAP_CYC = 10;
  localparam int NA = M * N, NB = N * L, NC = M * L;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_sel, start;
  logic [8:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        busy, done, err;
  logic [8:0]  res_raddr;
  logic [15:0] res_rdata;
  logic [7:0]  a_tdata, b_tdata;
  logic        a_tvalid, a_tready, a_tlast, b_tvalid, b_tready, b_tlast;
  logic [15:0] c_tdata;
  logic        c_tvalid, c_tready, c_tlast;

  always #5 clk = ~clk;

  axis_sa_host_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .done(done), .err(err),
    .res_raddr(res_raddr), .res_rdata(res_rdata),
    .m_axis_a_tdata(a_tdata), .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_tready), .m_axis_a_tlast(a_tlast),
    .m_axis_b_tdata(b_tdata), .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_tready), .m_axis_b_tlast(b_tlast),
    .s_axis_c_tdata(c_tdata), .s_axis_c_tvalid(c_tvalid), .s_axis_c_tready(c_tready), .s_axis_c_tlast(c_tlast)
  );

  logic [7:0]  a_img [NA];
  logic [7:0]  b_img [NB];
  logic [15:0] c_gold [NC];

  int passed = 0, total = 0;
  int r_a_hs, r_a_derr, r_a_lastpos, r_a_lastcnt, r_a_stab, r_a_first;
  int r_b_hs, r_b_derr, r_b_lastpos, r_b_lastcnt;
  int r_done_cnt, r_done_at, r_busy_at_done, r_busy_after, r_ctready_after;
  int r_overlap, r_err_first, r_err_drop, r_err_start, r_busy_start, r_gap, r_timeout;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    cfg_we = 0; cfg_sel = 0; cfg_addr = '0; cfg_wdata = '0; start = 0;
    a_tready = 0; b_tready = 0; c_tvalid = 0; c_tdata = '0; c_tlast = 0; res_raddr = '0;
  endtask

  // Builds A and B, computes C = A*B mod 2^16 and writes both matrices into the DUT.
  task automatic load_images(input bit rnd);
    logic [31:0] acc;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) a_img[i*N+j] = rnd ? 8'($urandom) : 8'(i + j);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < L; j++) b_img[i*L+j] = rnd ? 8'($urandom) : 8'(2*i + j + 1);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < L; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc = acc + 32'(a_img[i*N+k]) * 32'(b_img[k*L+j]);
        c_gold[i*L+j] = acc[15:0];
      end
    for (int e = 0; e < NA + NB; e++) begin
      cfg_we    = 1;
      cfg_sel   = (e >= NA);
      cfg_addr  = (e >= NA) ? 9'(e - NA) : 9'(e);
      cfg_wdata = (e >= NA) ? b_img[e-NA] : a_img[e];
      @(negedge clk);
    end
    cfg_we = 0;
  endtask

  task automatic readback(output int nbad);
    nbad = 0;
    for (int i = 0; i < NC; i++) begin
      res_raddr = 9'(i);
      @(negedge clk);
      if (res_rdata !== c_gold[i]) nbad++;
    end
  endtask

  // One run; the bench acts as A/B sink and as the C source replaying c_gold.
  task automatic run(input bit a_tog, input bit c_rand, input int early_at,
                     input int guard_at, input int abort_at, input int pre_w);
    bit a_rdy, a_stall, done_seen, finished, guard_done;
    logic [7:0] a_hold;
    logic a_hold_last;
    int c_sent, cyc, last_a_cyc, first_b_cyc;
    r_a_hs = 0; r_a_derr = 0; r_a_lastpos = -1; r_a_lastcnt = 0; r_a_stab = 0; r_a_first = -1;
    r_b_hs = 0; r_b_derr = 0; r_b_lastpos = -1; r_b_lastcnt = 0;
    r_done_cnt = 0; r_done_at = -1; r_busy_at_done = -1; r_busy_after = -1; r_ctready_after = -1;
    r_overlap = 0; r_err_first = -1; r_err_drop = 0; r_timeout = 0;
    a_rdy = 0; a_stall = 0; a_hold = 0; a_hold_last = 0; done_seen = 0; finished = 0; guard_done = 0;
    c_sent = 0; cyc = 0; last_a_cyc = -1; first_b_cyc = -1;
    start = 1;
    if (pre_w >= 0) begin
      cfg_we = 1; cfg_sel = 0; cfg_addr = 0; cfg_wdata = 8'(pre_w); a_img[0] = 8'(pre_w);
    end
    @(negedge clk);
    start = 0; cfg_we = 0;
    r_err_start = int'(err); r_busy_start = int'(busy);
    while (!finished && cyc < 6000) begin
      if (err && r_err_first < 0) r_err_first = c_sent;
      if (!err && r_err_first >= 0) r_err_drop++;
      if (done_seen) begin
        r_busy_after = int'(busy); r_ctready_after = int'(c_tready); finished = 1;
      end else if (abort_at >= 0 && b_tvalid && r_b_hs == abort_at) begin
        rst_n = 0;
        #1;
        chk("reset_b_tvalid", b_tvalid, 0);
        chk("reset_busy", busy, 0);
        finished = 1;
      end else begin
        if (done) begin
          r_done_cnt++; r_done_at = c_sent; r_busy_at_done = int'(busy); done_seen = 1;
        end
        if ((b_tvalid && r_a_hs < NA) || (a_tvalid && r_a_hs >= NA) || (a_tvalid && b_tvalid)) r_overlap++;
        if (c_tready && r_a_hs < NA) r_overlap++;
        // A sink
        if (a_stall && (!a_tvalid || a_tdata !== a_hold || a_tlast !== a_hold_last)) r_a_stab++;
        a_rdy = a_tog ? ~a_rdy : 1'b1;
        a_tready = a_rdy;
        if (a_tvalid && a_rdy) begin
          if (r_a_hs == 0) r_a_first = int'(a_tdata);
          if (r_a_hs >= NA) r_a_derr++;
          else if (a_tdata !== a_img[r_a_hs]) r_a_derr++;
          if (a_tlast) begin r_a_lastpos = r_a_hs; r_a_lastcnt++; end
          r_a_hs++;
          if (r_a_hs == NA) last_a_cyc = cyc;
        end
        a_stall = a_tvalid && !a_rdy; a_hold = a_tdata; a_hold_last = a_tlast;
        // B sink, always ready
        b_tready = 1;
        if (b_tvalid) begin
          if (first_b_cyc < 0) first_b_cyc = cyc;
          if (r_b_hs >= NB) r_b_derr++;
          else if (b_tdata !== b_img[r_b_hs]) r_b_derr++;
          if (b_tlast) begin r_b_lastpos = r_b_hs; r_b_lastcnt++; end
          r_b_hs++;
        end
        // busy-guard pokes
        if (guard_at >= 0 && r_b_hs == guard_at && !guard_done) begin
          start = 1; cfg_we = 1; cfg_sel = 0; cfg_addr = 0; cfg_wdata = 8'hFF; guard_done = 1;
        end else begin
          start = 0; cfg_we = 0;
        end
        // C source
        if (c_tready && c_sent < NC && (!c_rand || $urandom_range(0, 1) == 1)) begin
          c_tvalid = 1;
          c_tdata  = c_gold[c_sent];
          c_tlast  = (c_sent == NC - 1) || (early_at >= 0 && c_sent == early_at);
          c_sent++;
        end else begin
          c_tvalid = 0; c_tlast = 0;
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) r_timeout = 1;
    r_gap = first_b_cyc - last_a_cyc - 1;
    clear_inputs();
  endtask

  task automatic check_run(input string t);
    chk({t, "_timeout"}, r_timeout, 0);
    chk({t, "_busy_start"}, r_busy_start, 1);
    chk({t, "_a_beats"}, r_a_hs, NA);
    chk({t, "_a_data"}, r_a_derr, 0);
    chk({t, "_a_stable"}, r_a_stab, 0);
    chk({t, "_a_tlast_pos"}, r_a_lastpos, NA - 1);
    chk({t, "_a_tlast_cnt"}, r_a_lastcnt, 1);
    chk({t, "_b_beats"}, r_b_hs, NB);
    chk({t, "_b_data"}, r_b_derr, 0);
    chk({t, "_b_tlast_pos"}, r_b_lastpos, NB - 1);
    chk({t, "_b_tlast_cnt"}, r_b_lastcnt, 1);
    chk({t, "_done_cnt"}, r_done_cnt, 1);
    chk({t, "_done_at"}, r_done_at, NC);
    chk({t, "_busy_at_done"}, r_busy_at_done, 1);
    chk({t, "_busy_after"}, r_busy_after, 0);
    chk({t, "_ctready_after"}, r_ctready_after, 0);
    chk({t, "_overlap"}, r_overlap, 0);
    chk({t, "_gap_min"}, (r_gap >= GAP_CYC), 1);
    chk({t, "_gap_max"}, (r_gap <= GAP_CYC + 2), 1);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_a_tvalid", a_tvalid, 0);
    chk("rst_a_tlast", a_tlast, 0);
    chk("rst_a_tdata", a_tdata, 0);
    chk("rst_b_tvalid", b_tvalid, 0);
    chk("rst_b_tlast", b_tlast, 0);
    chk("rst_b_tdata", b_tdata, 0);
    chk("rst_c_tready", c_tready, 0);
    chk("rst_res_rdata", res_rdata, 0);
    rst_n = 1;
    @(negedge clk);

    // 1: pattern loopback
    load_images(0);
    run(0, 0, -1, -1, -1, -1);
    check_run("s1");
    chk("s1_err", r_err_first, -1);
    readback(bad);
    chk("s1_result", bad, 0);

    // 2: random data, A backpressure
    load_images(1);
    run(1, 0, -1, -1, -1, -1);
    check_run("s2");
    readback(bad);
    chk("s2_result", bad, 0);

    // 3: early C tlast, then restart clears err
    run(0, 0, 100, -1, -1, -1);
    check_run("s3");
    chk("s3_err_first", r_err_first, 101);
    chk("s3_err_sticky", r_err_drop, 0);
    chk("s3_err_end", err, 1);
    run(0, 0, -1, -1, -1, -1);
    check_run("s3b");
    chk("s3b_err_start", r_err_start, 0);
    chk("s3b_err", r_err_first, -1);

    // 4: start and cfg_we ignored while busy
    load_images(0);
    run(0, 0, -1, 10, -1, -1);
    check_run("s4");
    run(0, 0, -1, -1, -1, -1);
    check_run("s4b");
    chk("s4b_a_first", r_a_first, 0);

    // 5: reset during SEND_B beat 50, then a clean run
    run(0, 0, -1, -1, 50, -1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, 0, -1, -1, -1, -1);
    check_run("s5");
    chk("s5_a_first", r_a_first, 0);
    chk("s5_err", r_err_first, -1);

    // 6: C stalls, with a load landing in the start cycle
    run(0, 1, -1, -1, -1, 8'h5A);
    check_run("s6");
    chk("s6_a_first", r_a_first, 8'h5A);
    readback(bad);
    chk("s6_result", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
